pong_game_ctrl: RTL and testbench

PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

---
 rtl/pong_game_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: frame-ticked Pong game controller.
// Paddles and ball advance once per frame, on the falling edge of vsync.
// The ball bounces off walls and paddles, and the FSM keeps score.
// Optional macro PONG_AI_EN: paddle 2 tracks the ball and p2_up/p2_dn are ignored.
module pong_game_ctrl #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int PAD_W      = 8,
    parameter int PAD_H      = 64,
    parameter int BALL_SZ    = 8,
    parameter int PAD_SPEED  = 4,
    parameter int BALL_SPEED = 2,
    parameter int WIN_SCORE  = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vsync,
    input  logic       p1_up,
    input  logic       p1_dn,
    input  logic       p2_up,
    input  logic       p2_dn,
    input  logic       serve,
    output logic [9:0] x1,
    output logic [9:0] y1,
    output logic [9:0] x2,
    output logic [9:0] y2,
    output logic [9:0] xb,
    output logic [9:0] yb,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [1:0] game_state
);

    typedef enum logic [1:0] {
        SERVE = 2'd0,
        PLAY  = 2'd1,
        POINT = 2'd2,
        OVER  = 2'd3
    } state_t;

    localparam logic [9:0] X1_POS    = 10'(16);
    localparam logic [9:0] X2_POS    = 10'(H_ACTIVE - 24);
    localparam logic [9:0] PAD_MAX   = 10'(V_ACTIVE - PAD_H);
    localparam logic [9:0] PAD_MID   = 10'((V_ACTIVE - PAD_H) / 2);
    localparam logic [9:0] BALL_XC   = 10'((H_ACTIVE - BALL_SZ) / 2);
    localparam logic [9:0] BALL_YC   = 10'((V_ACTIVE - BALL_SZ) / 2);
    localparam logic [9:0] BALL_XMAX = 10'(H_ACTIVE - BALL_SZ);
    localparam logic [9:0] BALL_YMAX = 10'(V_ACTIVE - BALL_SZ);
    localparam logic [9:0] PW        = 10'(PAD_W);
    localparam logic [9:0] PH        = 10'(PAD_H);
    localparam logic [9:0] BSZ       = 10'(BALL_SZ);
    localparam logic [9:0] PSPD      = 10'(PAD_SPEED);
    localparam logic [9:0] BSPD      = 10'(BALL_SPEED);
    localparam logic [3:0] WIN       = 4'(WIN_SCORE);

    state_t     state_q, state_d;
    logic       vsync_q;
    logic [9:0] y1_q, y1_d, y2_q, y2_d, xb_q, xb_d, yb_q, yb_d;
    logic       dx_q, dx_d, dy_q, dy_d;
    logic       credit1_q, credit1_d;
    logic [3:0] score1_q, score1_d, score2_q, score2_d;
    logic [3:0] score1Inc, score2Inc;
    logic       tick, p2Up, p2Dn;
    logic       hit1, hit2, miss1, miss2;

    // One paddle step: up and down together cancel, and the result is clamped with no wrap.
    function automatic logic [9:0] padStep(input logic [9:0] y, input logic up, input logic dn);
        logic [9:0] r;
        r = y;
        if (up && !dn) begin
            r = (y < PSPD) ? 10'd0 : y - PSPD;
        end else if (dn && !up) begin
            r = (y + PSPD > PAD_MAX) ? PAD_MAX : y + PSPD;
        end
        return r;
    endfunction

    assign tick = vsync_q & ~vsync;

`ifdef PONG_AI_EN
    localparam logic signed [11:0] AI_OFF = 12'((PAD_H - BALL_SZ) / 2);
    localparam logic signed [11:0] PSPD_S = 12'(PAD_SPEED);
    logic signed [11:0] aiTarget, y2Signed;
    logic               unusedButtons;
    assign unusedButtons = p2_up ^ p2_dn;
    assign aiTarget      = $signed({2'b00, yb_q}) - AI_OFF;
    assign y2Signed      = $signed({2'b00, y2_q});
    assign p2Dn          = (aiTarget >= y2Signed + PSPD_S);
    assign p2Up          = (aiTarget + PSPD_S <= y2Signed);
`else
    assign p2Up = p2_up;
    assign p2Dn = p2_dn;
`endif

    // The paddle test is written as xb <= x1+PAD_W+speed, so a small xb cannot underflow.
    assign hit1  = !dx_q && (xb_q >= X1_POS) && (xb_q <= X1_POS + PW + BSPD)
                   && (yb_q + BSZ > y1_q) && (yb_q < y1_q + PH);
    assign hit2  = dx_q && (xb_q + BSPD + BSZ >= X2_POS) && (xb_q + BSZ <= X2_POS + PW)
                   && (yb_q + BSZ > y2_q) && (yb_q < y2_q + PH);
    assign miss1 = !dx_q && (xb_q < BSPD);
    assign miss2 = dx_q && (xb_q + BSPD > BALL_XMAX);

    assign score1Inc = (score1_q < WIN) ? score1_q + 4'd1 : score1_q;
    assign score2Inc = (score2_q < WIN) ? score2_q + 4'd1 : score2_q;

    // Register all game state, with reset overriding every other condition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SERVE;
            vsync_q   <= 1'b1;
            y1_q      <= PAD_MID;
            y2_q      <= PAD_MID;
            xb_q      <= BALL_XC;
            yb_q      <= BALL_YC;
            dx_q      <= 1'b1;
            dy_q      <= 1'b1;
            credit1_q <= 1'b0;
            score1_q  <= 4'd0;
            score2_q  <= 4'd0;
        end else begin
            state_q   <= state_d;
            vsync_q   <= vsync;
            y1_q      <= y1_d;
            y2_q      <= y2_d;
            xb_q      <= xb_d;
            yb_q      <= yb_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            credit1_q <= credit1_d;
            score1_q  <= score1_d;
            score2_q  <= score2_d;
        end
    end

    // Compute the next game state; the x and y axes of the ball are resolved independently.
    always_comb begin
        state_d   = state_q;
        y1_d      = y1_q;
        y2_d      = y2_q;
        xb_d      = xb_q;
        yb_d      = yb_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        credit1_d = credit1_q;
        score1_d  = score1_q;
        score2_d  = score2_q;
        case (state_q)
            SERVE: begin
                xb_d = BALL_XC;
                yb_d = BALL_YC;
                if (tick) begin
                    y1_d = padStep(y1_q, p1_up, p1_dn);
                    y2_d = padStep(y2_q, p2Up, p2Dn);
                end
                if (serve) begin
                    state_d = PLAY;
                end
            end
            PLAY: begin
                if (tick) begin
                    y1_d = padStep(y1_q, p1_up, p1_dn);
                    y2_d = padStep(y2_q, p2Up, p2Dn);
                    if (!dy_q) begin
                        if (yb_q < BSPD) begin
                            yb_d = 10'd0;
                            dy_d = 1'b1;
                        end else begin
                            yb_d = yb_q - BSPD;
                        end
                    end else begin
                        if (yb_q + BSPD > BALL_YMAX) begin
                            yb_d = BALL_YMAX;
                            dy_d = 1'b0;
                        end else begin
                            yb_d = yb_q + BSPD;
                        end
                    end
                    if (miss1 || miss2) begin
                        state_d   = POINT;
                        credit1_d = miss2;
                    end else if (hit1) begin
                        xb_d = X1_POS + PW;
                        dx_d = 1'b1;
                    end else if (hit2) begin
                        xb_d = X2_POS - BSZ;
                        dx_d = 1'b0;
                    end else begin
                        xb_d = dx_q ? xb_q + BSPD : xb_q - BSPD;
                    end
                end
            end
            POINT: begin
                xb_d = BALL_XC;
                yb_d = BALL_YC;
                dy_d = 1'b1;
                dx_d = credit1_q;
                if (credit1_q) begin
                    score1_d = score1Inc;
                    state_d  = (score1Inc == WIN) ? OVER : SERVE;
                end else begin
                    score2_d = score2Inc;
                    state_d  = (score2Inc == WIN) ? OVER : SERVE;
                end
            end
            OVER: begin
                if (serve) begin
                    score1_d = 4'd0;
                    score2_d = 4'd0;
                    state_d  = SERVE;
                end
            end
            default: state_d = SERVE;
        endcase
    end

    assign x1         = X1_POS;
    assign x2         = X2_POS;
    assign y1         = y1_q;
    assign y2         = y2_q;
    assign xb         = xb_q;
    assign yb         = yb_q;
    assign score1     = score1_q;
    assign score2     = score2_q;
    assign game_state = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: directed scenarios for pong_game_ctrl (default build, PONG_AI_EN undefined).
// Expected positions are hand-derived from the ball and paddle rules, frame by frame.
module tb_pong_game_ctrl;

    logic       clk = 1'b0;
    logic       rst, vsync, p1_up, p1_dn, p2_up, p2_dn, serve;
    logic [9:0] x1, y1, x2, y2, xb, yb;
    logic [3:0] score1, score2;
    logic [1:0] game_state;
    int         nCompared;
    int         nMismatched;

    pong_game_ctrl dut (
        .clk(clk), .rst(rst), .vsync(vsync),
        .p1_up(p1_up), .p1_dn(p1_dn), .p2_up(p2_up), .p2_dn(p2_dn), .serve(serve),
        .x1(x1), .y1(y1), .x2(x2), .y2(y2), .xb(xb), .yb(yb),
        .score1(score1), .score2(score2), .game_state(game_state)
    );

    // 100 MHz bench clock; the design is rate-agnostic.
    always #5 clk = ~clk;

    // n frames: vsync is low for one clock, so each frame gives exactly one tick edge.
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            vsync = 1'b0;
            @(negedge clk);
            vsync = 1'b1;
        end
    endtask

    // Single-cycle serve pulse; returns just after the edge that sampled it.
    task automatic pressServe();
        @(negedge clk);
        serve = 1'b1;
        @(negedge clk);
        serve = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        nCompared++;
        if (game_state !== 2'd0) begin nMismatched++; $display("[TB] FAIL reset_state: got %0d expected 0", game_state); end
        nCompared++;
        if (y1 !== 10'd208 || y2 !== 10'd208) begin nMismatched++; $display("[TB] FAIL reset_paddles: got y1=%0d y2=%0d expected 208 208", y1, y2); end
        nCompared++;
        if (xb !== 10'd316 || yb !== 10'd236) begin nMismatched++; $display("[TB] FAIL reset_ball: got %0d,%0d expected 316,236", xb, yb); end
        nCompared++;
        if (x1 !== 10'd16 || x2 !== 10'd616) begin nMismatched++; $display("[TB] FAIL paddle_x: got %0d,%0d expected 16,616", x1, x2); end
        nCompared++;
        if (score1 !== 4'd0 || score2 !== 4'd0) begin nMismatched++; $display("[TB] FAIL reset_scores: got %0d,%0d expected 0,0", score1, score2); end
        rst = 1'b0;
    endtask

    task automatic test_paddles();
        p1_dn = 1'b1;
        repeat (6) @(negedge clk);
        nCompared++;
        if (y1 !== 10'd208) begin nMismatched++; $display("[TB] FAIL no_tick_hold: got %0d expected 208", y1); end
        p1_dn = 1'b0;
        p1_up = 1'b1;
        ticks(1);
        nCompared++;
        if (y1 !== 10'd204) begin nMismatched++; $display("[TB] FAIL one_step_up: got %0d expected 204", y1); end
        ticks(59);
        nCompared++;
        if (y1 !== 10'd0) begin nMismatched++; $display("[TB] FAIL top_clamp: got %0d expected 0", y1); end
        p1_up = 1'b0;
        p1_dn = 1'b1;
        ticks(120);
        nCompared++;
        if (y1 !== 10'd416) begin nMismatched++; $display("[TB] FAIL bottom_clamp: got %0d expected 416", y1); end
        p1_up = 1'b1;
        ticks(5);
        nCompared++;
        if (y1 !== 10'd416) begin nMismatched++; $display("[TB] FAIL up_dn_hold: got %0d expected 416", y1); end
        p1_dn = 1'b0;
        ticks(104);
        p1_up = 1'b0;
        p2_dn = 1'b1;
        ticks(48);
        p2_dn = 1'b0;
        nCompared++;
        if (y1 !== 10'd0 || y2 !== 10'd400) begin nMismatched++; $display("[TB] FAIL paddle_setup: got y1=%0d y2=%0d expected 0 400", y1, y2); end
        nCompared++;
        if (xb !== 10'd316 || yb !== 10'd236 || game_state !== 2'd0) begin
            nMismatched++; $display("[TB] FAIL serve_hold: got %0d,%0d st=%0d expected 316,236 st=0", xb, yb, game_state);
        end
    endtask

    // Paddle 2 returns the ball, it bounces off the top wall, and player 1 misses.
    task automatic test_rally_p2_point();
        pressServe();
        nCompared++;
        if (game_state !== 2'd1) begin nMismatched++; $display("[TB] FAIL serve_to_play: got %0d expected 1", game_state); end
        ticks(145);
        nCompared++;
        if (xb !== 10'd606 || yb !== 10'd420) begin nMismatched++; $display("[TB] FAIL pre_p2_hit: got %0d,%0d expected 606,420", xb, yb); end
        ticks(1);
        nCompared++;
        if (xb !== 10'd608 || yb !== 10'd418) begin nMismatched++; $display("[TB] FAIL p2_hit: got %0d,%0d expected 608,418", xb, yb); end
        ticks(208);
        nCompared++;
        if (xb !== 10'd192 || yb !== 10'd2) begin nMismatched++; $display("[TB] FAIL near_top: got %0d,%0d expected 192,2", xb, yb); end
        ticks(1);
        nCompared++;
        if (xb !== 10'd190 || yb !== 10'd0) begin nMismatched++; $display("[TB] FAIL reach_top: got %0d,%0d expected 190,0", xb, yb); end
        ticks(1);
        nCompared++;
        if (xb !== 10'd188 || yb !== 10'd0) begin nMismatched++; $display("[TB] FAIL top_bounce: got %0d,%0d expected 188,0", xb, yb); end
        ticks(1);
        nCompared++;
        if (xb !== 10'd186 || yb !== 10'd2) begin nMismatched++; $display("[TB] FAIL after_top: got %0d,%0d expected 186,2", xb, yb); end
        ticks(93);
        nCompared++;
        if (xb !== 10'd0 || yb !== 10'd188 || game_state !== 2'd1) begin
            nMismatched++; $display("[TB] FAIL left_edge: got %0d,%0d st=%0d expected 0,188 st=1", xb, yb, game_state);
        end
        ticks(1);
        nCompared++;
        if (game_state !== 2'd2 || score2 !== 4'd0) begin nMismatched++; $display("[TB] FAIL miss_point: got st=%0d s2=%0d expected st=2 s2=0", game_state, score2); end
        @(negedge clk);
        nCompared++;
        if (game_state !== 2'd0 || score2 !== 4'd1 || score1 !== 4'd0) begin
            nMismatched++; $display("[TB] FAIL p2_scored: got st=%0d s1=%0d s2=%0d expected 0 0 1", game_state, score1, score2);
        end
        nCompared++;
        if (xb !== 10'd316 || yb !== 10'd236) begin nMismatched++; $display("[TB] FAIL recentre: got %0d,%0d expected 316,236", xb, yb); end
    endtask

    // Ball served toward player 1 (loser of the last point); paddle 1 returns it and player 2 misses.
    task automatic test_paddle_hit();
        p1_dn = 1'b1;
        ticks(100);
        p1_dn = 1'b0;
        nCompared++;
        if (y1 !== 10'd400) begin nMismatched++; $display("[TB] FAIL p1_setup: got %0d expected 400", y1); end
        pressServe();
        ticks(145);
        nCompared++;
        if (xb !== 10'd26 || yb !== 10'd420) begin nMismatched++; $display("[TB] FAIL pre_p1_hit: got %0d,%0d expected 26,420", xb, yb); end
        ticks(1);
        nCompared++;
        if (xb !== 10'd24 || yb !== 10'd418) begin nMismatched++; $display("[TB] FAIL p1_hit: got %0d,%0d expected 24,418", xb, yb); end
        ticks(1);
        nCompared++;
        if (xb !== 10'd26 || yb !== 10'd416) begin nMismatched++; $display("[TB] FAIL p1_return: got %0d,%0d expected 26,416", xb, yb); end
        ticks(303);
        nCompared++;
        if (xb !== 10'd632 || yb !== 10'd188) begin nMismatched++; $display("[TB] FAIL right_edge: got %0d,%0d expected 632,188", xb, yb); end
        ticks(1);
        nCompared++;
        if (game_state !== 2'd2) begin nMismatched++; $display("[TB] FAIL p1_point_state: got %0d expected 2", game_state); end
        @(negedge clk);
        nCompared++;
        if (game_state !== 2'd0 || score1 !== 4'd1 || score2 !== 4'd1) begin
            nMismatched++; $display("[TB] FAIL p1_scored: got st=%0d s1=%0d s2=%0d expected 0 1 1", game_state, score1, score2);
        end
    endtask

    // Player 1 takes eight more points to reach 9; then OVER freezes play until serve restarts it.
    task automatic test_win();
        logic [1:0] expState;
        p2_up = 1'b1;
        ticks(48);
        p2_up = 1'b0;
        nCompared++;
        if (y2 !== 10'd208) begin nMismatched++; $display("[TB] FAIL p2_setup: got %0d expected 208", y2); end
        for (int r = 2; r <= 9; r++) begin
            pressServe();
            ticks(158);
            nCompared++;
            if (xb !== 10'd632 || yb !== 10'd394) begin nMismatched++; $display("[TB] FAIL round%0d_pos: got %0d,%0d expected 632,394", r, xb, yb); end
            ticks(1);
            @(negedge clk);
            expState = (r == 9) ? 2'd3 : 2'd0;
            nCompared++;
            if (score1 !== 4'(r) || game_state !== expState) begin
                nMismatched++; $display("[TB] FAIL round%0d_score: got s1=%0d st=%0d expected s1=%0d st=%0d", r, score1, game_state, r, expState);
            end
        end
        p1_up = 1'b1;
        ticks(3);
        p1_up = 1'b0;
        nCompared++;
        if (y1 !== 10'd400 || xb !== 10'd316 || yb !== 10'd236 || game_state !== 2'd3) begin
            nMismatched++; $display("[TB] FAIL over_freeze: got y1=%0d ball=%0d,%0d st=%0d expected 400 316,236 3", y1, xb, yb, game_state);
        end
        pressServe();
        nCompared++;
        if (game_state !== 2'd0 || score1 !== 4'd0 || score2 !== 4'd0) begin
            nMismatched++; $display("[TB] FAIL restart: got st=%0d s1=%0d s2=%0d expected 0 0 0", game_state, score1, score2);
        end
    endtask

    // Reset in mid-rally with a nonzero score, with serve and a pending tick asserted at the same time.
    task automatic test_reset_mid_play();
        pressServe();
        ticks(159);
        @(negedge clk);
        nCompared++;
        if (score1 !== 4'd1 || game_state !== 2'd0) begin nMismatched++; $display("[TB] FAIL pre_reset_score: got s1=%0d st=%0d expected 1 0", score1, game_state); end
        pressServe();
        ticks(20);
        nCompared++;
        if (xb !== 10'd356 || yb !== 10'd276 || game_state !== 2'd1) begin
            nMismatched++; $display("[TB] FAIL mid_play: got %0d,%0d st=%0d expected 356,276 st=1", xb, yb, game_state);
        end
        @(negedge clk);
        rst   = 1'b1;
        serve = 1'b1;
        vsync = 1'b0;
        p1_dn = 1'b1;
        @(negedge clk);
        nCompared++;
        if (game_state !== 2'd0 || y1 !== 10'd208 || y2 !== 10'd208 || xb !== 10'd316 || yb !== 10'd236 || score1 !== 4'd0 || score2 !== 4'd0) begin
            nMismatched++;
            $display("[TB] FAIL reset_in_play: got st=%0d y1=%0d y2=%0d ball=%0d,%0d s=%0d,%0d expected 0 208 208 316,236 0,0",
                     game_state, y1, y2, xb, yb, score1, score2);
        end
        rst   = 1'b0;
        serve = 1'b0;
        @(negedge clk);
        nCompared++;
        if (y1 !== 10'd212 || game_state !== 2'd0) begin nMismatched++; $display("[TB] FAIL vsync_reg_reset: got y1=%0d st=%0d expected 212 0", y1, game_state); end
        p1_dn = 1'b0;
        vsync = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        vsync = 1'b1;
        p1_up = 1'b0;
        p1_dn = 1'b0;
        p2_up = 1'b0;
        p2_dn = 1'b0;
        serve = 1'b0;
        nCompared = 0;
        nMismatched = 0;
        test_reset();
        test_paddles();
        test_rally_p2_point();
        test_paddle_hit();
        test_win();
        test_reset_mid_play();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
